// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter: sole bus master for one spart; programs the baud divisor,
// then serves RX reads with priority over round-robin TX writes.
module spart_bus_arbiter #(
    parameter logic [15:0] DIV_4800  = 16'h0515,
    parameter logic [15:0] DIV_9600  = 16'h028A,
    parameter logic [15:0] DIV_19200 = 16'h0144,
    parameter logic [15:0] DIV_38400 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    input  logic       tx0_valid,
    input  logic [7:0] tx0_data,
    output logic       tx0_ready,
    input  logic       tx1_valid,
    input  logic [7:0] tx1_data,
    output logic       tx1_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       cfg_done
);
    typedef enum logic [2:0] {
        S_CFG_LO, S_CFG_HI, S_IDLE, S_TX_WR, S_TX_WAIT, S_RX_RD, S_RX_WAIT
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_br_cfg_q;
    logic        r_rr_last, r_gnt, r_cfg_done, r_rx_valid;
    logic [7:0]  r_rx_data, w_dout;
    logic [15:0] w_div;
    logic        w_cfg_chg, w_tx_req, w_gnt;

    assign w_div = r_br_cfg_q == 2'b00 ? DIV_4800 :
                   r_br_cfg_q == 2'b01 ? DIV_9600 :
                   r_br_cfg_q == 2'b10 ? DIV_19200 : DIV_38400;
    assign w_cfg_chg = br_cfg != r_br_cfg_q;
    assign w_tx_req  = tbr && (tx0_valid || tx1_valid);
    // 1 selects requester 1; on a tie the one that did not win last time goes
    assign w_gnt     = (tx0_valid && tx1_valid) ? ~r_rr_last : tx1_valid;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_CFG_LO;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CFG_LO: w_next = S_CFG_HI;
            S_CFG_HI: w_next = S_IDLE;
            S_IDLE:   w_next = w_cfg_chg ? S_CFG_LO : rda ? S_RX_RD : w_tx_req ? S_TX_WR : S_IDLE;
            S_TX_WR:  w_next = S_TX_WAIT;
            S_RX_RD:  w_next = S_RX_WAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are forced to their idle values while rst is held so a transfer is dropped at once
    always_comb begin
        iocs      = 1'b0;
        iorw      = 1'b1;
        ioaddr    = 2'b00;
        w_dout    = 8'h00;
        tx0_ready = 1'b0;
        tx1_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    w_dout = w_div[7:0];
                end
                S_CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    w_dout = w_div[15:8];
                end
                S_TX_WR: begin
                    iocs      = 1'b1;
                    iorw      = 1'b0;
                    w_dout    = r_gnt ? tx1_data : tx0_data;
                    tx0_ready = ~r_gnt;
                    tx1_ready = r_gnt;
                end
                S_RX_RD: iocs = 1'b1;
                default: ;
            endcase
        end
    end

    assign databus = (iocs && !iorw) ? w_dout : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cfg_q <= br_cfg;
            r_rr_last  <= 1'b1;
            r_gnt      <= 1'b0;
            r_cfg_done <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_valid <= r_state == S_RX_RD;
            if (r_state == S_RX_RD)
                r_rx_data <= databus;
            if (r_state == S_CFG_HI)
                r_cfg_done <= 1'b1;
            if (r_state == S_IDLE) begin
                r_gnt <= w_gnt;
                if (w_cfg_chg) begin
                    r_br_cfg_q <= br_cfg;
                    r_cfg_done <= 1'b0;
                end
            end
            if (r_state == S_TX_WR)
                r_rr_last <= r_gnt;
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign cfg_done = r_cfg_done;
endmodule
